// File: rtl/dm_pkg.sv
// dm_pkg: size and state encodings, default timeout and alignment rule for the data-memory controller.
package dm_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int DM_TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2, S_ERR = 2'd3} dm_state_t;
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) | ((size == SIZE_HALF) & a[0]) | ((size == SIZE_WORD) & (|a));
  endfunction
endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: selects the addressed byte/half from a memory word and sign- or zero-extends it.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_a,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = i_rdata[{i_a, 3'b000} +: 8];
  assign w_h = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_data = (i_size == SIZE_BYTE) ? {{24{i_signed & w_b[7]}}, w_b} :
                  (i_size == SIZE_HALF) ? {{16{i_signed & w_h[15]}}, w_h} : i_rdata;
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory controller with req/ack memory handshake and pipeline stall.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DM_TIMEOUT_DEF,
  parameter int TO_W           = 8
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  dm_state_t   r_state, w_next;
  logic        r_we, r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_mis, w_accept, w_ack, w_to, w_acc;
  logic [31:0] w_ext, w_wd;
  logic [3:0]  w_be;
  assign w_mis    = dm_misaligned(req_size, req_addr[1:0]);
  assign w_accept = (r_state == S_IDLE) & req_valid & ~w_mis;
  assign w_acc    = r_state == S_ACCESS;
  assign w_ack    = w_acc & mem_ack;
`ifdef DM_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;
  logic            r_bus_err;
  assign w_to    = w_acc & ~mem_ack & (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = (r_state == S_RESP) & r_bus_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt     <= w_accept ? '0 : (w_acc & ~mem_ack) ? r_cnt + 1'b1 : r_cnt;
      r_bus_err <= w_accept ? 1'b0 : w_to ? 1'b1 : r_bus_err;
    end
  end
`else
  assign w_to    = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = req_valid ? (w_mis ? S_ERR : S_ACCESS) : S_IDLE;
      S_ACCESS: w_next = (mem_ack | w_to) ? S_RESP : S_ACCESS;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (w_ack)     r_rdata <= r_we ? '0 : w_ext;
      else if (w_to) r_rdata <= '0;
    end
  end
  dm_load_ext u_ext (
    .i_rdata  (mem_rdata),
    .i_a      (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );
  assign w_be = ~r_we                 ? 4'b1111 :
                (r_size == SIZE_BYTE) ? 4'b0001 << r_addr[1:0] :
                (r_size == SIZE_HALF) ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = (r_size == SIZE_BYTE) ? {4{r_wdata[7:0]}} :
                (r_size == SIZE_HALF) ? {2{r_wdata[15:0]}} : r_wdata;
  always_comb begin
    req_ready    = rst_n & (r_state == S_IDLE);
    mem_req      = w_acc;
    mem_we       = w_acc & r_we;
    mem_addr     = w_acc ? {r_addr[31:2], 2'b00} : '0;
    mem_be       = w_acc ? w_be : '0;
    mem_wdata    = (w_acc & r_we) ? w_wd : '0;
    resp_valid   = (r_state == S_RESP) | (r_state == S_ERR);
    misalign_err = r_state == S_ERR;
    resp_rdata   = (r_state == S_RESP) ? r_rdata : '0;
    stall        = rst_n & req_valid & ~resp_valid;
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed self-checking bench with a per-cycle expectation model for dm_access_ctrl.
module tb_dm_access_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, misalign_err, bus_err, stall, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int n_chk = 0, n_pass = 0;
  logic chk_en = 1'b0;
  logic e_rdy, e_stl, e_req, e_rv, e_we, e_mis, e_bus;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0] e_be;
  int req_cnt;
  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0] last_be;
  logic last_we, last_mis, last_bus;
  always #5 clk = ~clk;
  dm_access_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err), .bus_err(bus_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr, input logic [31:0] d);
    int a;
    longint v;
    a = int'(addr % 4);
    if (size == 2'd0) begin
      v = longint'((d >> (8 * a)) & 32'hFF);
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = longint'((d >> (16 * (a / 2))) & 32'hFFFF);
      if (sgn && v >= 32768) v = v - 65536;
    end else v = longint'(d);
    return v[31:0];
  endfunction
  function automatic logic [3:0] m_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (!we || size == 2'd2) return 4'hF;
    if (size == 2'd0) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction
  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
    return size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction
  always @(negedge clk) begin
    logic ok;
    if (chk_en) begin
      ok = req_ready == e_rdy && stall == e_stl && mem_req == e_req && resp_valid == e_rv;
      if (e_req) ok = ok && mem_we == e_we && mem_addr == e_addr && mem_be == e_be && (!e_we || mem_wdata == e_wdata);
      if (e_rv) ok = ok && resp_rdata == e_rdata && misalign_err == e_mis && bus_err == e_bus;
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL cycle t=%0t: got rdy=%b stl=%b req=%b rv=%b we=%b a=%h be=%h wd=%h rd=%h mis=%b bus=%b; want rdy=%b stl=%b req=%b rv=%b we=%b a=%h be=%h wd=%h rd=%h mis=%b bus=%b",
        $time, req_ready, stall, mem_req, resp_valid, mem_we, mem_addr, mem_be, mem_wdata, resp_rdata, misalign_err, bus_err,
        e_rdy, e_stl, e_req, e_rv, e_we, e_addr, e_be, e_wdata, e_rdata, e_mis, e_bus);
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask
  task automatic set_e(input logic rdy, input logic stl, input logic rq, input logic rv);
    e_rdy = rdy; e_stl = stl; e_req = rq; e_rv = rv;
  endtask
  task automatic step();
    @(negedge clk);
    if (mem_req) begin
      req_cnt++;
      last_we = mem_we; last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
    end
    if (resp_valid) begin
      last_rdata = resp_rdata; last_mis = misalign_err; last_bus = bus_err;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n);
    int acc;
    logic berr;
`ifdef DM_TIMEOUT_EN
    berr = wait_n >= 4;
    acc  = berr ? 4 : wait_n + 1;
`else
    berr = 1'b0;
    acc  = wait_n + 1;
`endif
    req_cnt = 0;
    last_mis = 1'b0; last_bus = 1'b0; last_rdata = 32'hXXXX_XXXX;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
    set_e(1, 1, 0, 0);
    step();
    if (m_mis(size, addr)) begin
      set_e(0, 0, 0, 1); e_rdata = '0; e_mis = 1'b1; e_bus = 1'b0;
      step();
    end else begin
      e_we = we; e_addr = addr & 32'hFFFF_FFFC; e_be = m_be(we, size, addr); e_wdata = m_wdata(size, wdata);
      for (int i = 0; i < acc; i++) begin
        mem_ack = !berr && i == acc - 1;
        mem_rdata = mem_ack ? rdata : ~rdata;
        set_e(0, 1, 1, 0);
        step();
      end
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      set_e(0, 0, 0, 1); e_rdata = (we || berr) ? 32'h0 : m_load(size, sgn, addr, rdata); e_mis = 1'b0; e_bus = berr;
      step();
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    set_e(1, 0, 0, 0);
    step();
  endtask
  initial begin
    #3;
    chk("reset_outputs", {32'h0, req_ready, resp_valid, misalign_err, bus_err, stall, mem_req, mem_we, mem_be, 21'h0},
        64'h0);
    chk("reset_bus", {mem_addr, mem_wdata | resp_rdata}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_e(1, 0, 0, 0); chk_en = 1'b1;
    step();
    chk("model_lb", m_load(2'd0, 1'b1, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("model_lhu", m_load(2'd1, 1'b0, 32'h4002, 32'h9ABC_0000), 32'h0000_9ABC);
    chk("model_sh_be", m_be(1'b1, 2'd1, 32'h2002), 4'b1100);
    run(0, 2'd0, 1, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    run(0, 2'd0, 0, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);
    run(1, 2'd1, 0, 32'h2002, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sh_mem", {last_we, last_be, last_addr}, {1'b1, 4'b1100, 32'h2000});
    chk("sh_wdata_rdata", {last_wdata, last_rdata}, {32'hBEEF_BEEF, 32'h0});
    run(0, 2'd2, 0, 32'h3001, 0, 32'h0, 0);
    chk("lw_mis", {last_mis, 8'(req_cnt)}, {1'b1, 8'd0});
    run(0, 2'd1, 1, 32'h3001, 0, 32'h0, 0);
    chk("lh_mis", {last_mis, 8'(req_cnt)}, {1'b1, 8'd0});
    run(0, 2'd1, 0, 32'h4002, 0, 32'h9ABC_0000, 3);
    chk("lhu_wait", {last_rdata, 8'(req_cnt)}, {32'h0000_9ABC, 8'd4});
    run(0, 2'd1, 1, 32'h4000, 0, 32'h1234_8001, 1);
    chk("lh_neg", last_rdata, 32'hFFFF_8001);
    run(0, 2'd0, 1, 32'h0010, 0, 32'h0000_007F, 0);
    run(0, 2'd2, 1, 32'h0020, 0, 32'hF0F0_0001, 2);
    chk("lw_pass", last_rdata, 32'hF0F0_0001);
    run(1, 2'd0, 0, 32'h0031, 32'h0000_00A5, 32'h0, 0);
    chk("sb1", {last_be, last_wdata}, {4'b0010, 32'hA5A5_A5A5});
    run(1, 2'd2, 0, 32'h0040, 32'h0123_4567, 32'h0, 1);
    run(0, 2'd3, 0, 32'h0050, 0, 32'h0, 0);
    chk("illegal_size", last_mis, 1'b1);
    run(1, 2'd1, 0, 32'h0060, 32'h1111_CAFE, 32'h0, 0);
    chk("sh0", {last_be, last_wdata}, {4'b0011, 32'hCAFE_CAFE});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h5000; mem_ack = 1'b0;
    set_e(1, 1, 0, 0);
    step();
    set_e(0, 1, 1, 0); e_we = 1'b0; e_addr = 32'h5000; e_be = 4'hF;
    step();
    step();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {mem_req, stall, resp_valid, req_ready}, 4'b0);
    @(posedge clk); #1;
    chk("rst_hold", {mem_req, stall, resp_valid, req_ready}, 4'b0);
    req_valid = 1'b0; rst_n = 1'b1;
    set_e(1, 0, 0, 0); chk_en = 1'b1;
    step();
    run(1, 2'd2, 0, 32'h7000, 32'hCAFE_F00D, 32'h0, 0);
    chk("sw_after_rst", {last_wdata, last_addr}, {32'hCAFE_F00D, 32'h7000});
`ifdef DM_TIMEOUT_EN
    run(0, 2'd2, 0, 32'h6000, 0, 32'h1111_2222, 10);
    chk("timeout", {last_bus, last_rdata, 8'(req_cnt)}, {1'b1, 32'h0, 8'd4});
    run(0, 2'd2, 0, 32'h6004, 0, 32'h1234_5678, 3);
    chk("ack_at_limit", {last_bus, last_rdata, 8'(req_cnt)}, {1'b0, 32'h1234_5678, 8'd4});
`endif
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Data-memory access controller for the MEM stage of the pipelined MIPS core.
- Write direction: narrows 32-bit store data into byte lanes, with byte enables for sb/sh/sw.
- Read direction: extracts the addressed byte or half from the returned word and sign- or zero-extends it to 32 bits for lb/lbu/lh/lhu/lw.
- Talks to a variable-latency memory through a req/ack handshake and stalls the pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without mem_ack before a bus error is raised. Used only with DM_TIMEOUT_EN.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage has a load or store.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- misalign_err  out  1  valid with resp_valid.
- bus_err  out  1  valid with resp_valid.
- stall  out  1  hold the pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory done; read data valid in the same cycle.
- mem_rdata  in  32  memory read word.

Behaviour:
- Reset: all outputs are 0, the state is IDLE and all latched fields are 0. Reset is asynchronous: asserting rst_n mid-access drops mem_req immediately and abandons the access.
- The FSM has four states: IDLE, ACCESS, RESP and ERR. req_ready = 1 only in IDLE.
- IDLE: on req_valid, check alignment. A request is misaligned if req_size = 11, if it is a half with addr[0] = 1, or if it is a word with addr[1:0] != 0.
  - Misaligned: go to ERR. No memory access is made.
  - Aligned: latch we/size/signed/addr/wdata and go to ACCESS.
- ACCESS: mem_req = 1 and all mem_* outputs are registered and held stable until mem_ack.
  - On mem_ack, capture the processed mem_rdata and go to RESP.
- RESP and ERR: each lasts exactly one cycle with resp_valid = 1, then returns to IDLE.
  - ERR sets misalign_err = 1 and resp_rdata = 0.
- stall = req_valid & ~resp_valid. It therefore also covers the acceptance cycle in IDLE.
- Latency: request accepted in cycle N, mem_req visible in N+1. With mem_ack in N+1, resp_valid is asserted in N+2. Each extra wait cycle adds one cycle. A misaligned request responds in N+1.
- mem_ack is ignored outside ACCESS.
- Store lanes, with a = addr[1:0]:
  - Byte: mem_be = 4'b0001 << a; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = a[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 4'b1111; mem_wdata = wdata.
- Loads: mem_be = 4'b1111.
  - Byte: take mem_rdata[8a+7:8a].
  - Half: take mem_rdata[16*a[1]+15 : 16*a[1]].
  - Byte and half are then sign- or zero-extended according to req_signed. Word is passed through unchanged and req_signed is ignored.
- Store responses always return resp_rdata = 0.

Optional Feature:
- Macro DM_TIMEOUT_EN.
- Defined: a counter cleared on entry to ACCESS increments each ACCESS cycle without mem_ack. When it reaches TIMEOUT_CYCLES:
  - mem_req deasserts;
  - the FSM goes to RESP with bus_err = 1 and resp_rdata = 0.
  - If mem_ack arrives in the same cycle as the limit, the ack wins.
- Undefined: ACCESS waits indefinitely; bus_err is tied to 0 and no counter logic exists.

Decomposition:
- Package dm_pkg holds the SIZE_BYTE, SIZE_HALF and SIZE_WORD encodings, the FSM state encodings, and the default TIMEOUT_CYCLES.
- One sub-module, dm_load_ext: purely combinational lane select plus sign/zero extension. Inputs are rdata, a, size and signed; the output is the 32-bit extended value.
- Store lane packing stays inline in dm_access_ctrl.

Test Plan:
- lb at addr 0x1003, mem_rdata 0x80FF_1234, ack on first ACCESS cycle -> resp_rdata 0xFFFF_FF80 two cycles after acceptance; lbu on the same access -> 0x0000_0080.
- sh at addr 0x2002, wdata 0xDEAD_BEEF -> mem_addr 0x2000, mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_we = 1; resp_rdata 0.
- lw at addr 0x3001 -> ERR one cycle later, misalign_err = 1, mem_req never asserted; lh at 0x3001 gives the same result.
- lhu at 0x4002, mem_ack delayed 3 cycles, mem_rdata 0x9ABC_0000 -> mem_req held stable 4 cycles, stall high throughout, resp_rdata 0x0000_9ABC.
- rst_n pulsed low during ACCESS -> mem_req, stall and resp_valid go to 0 immediately; a subsequent sw completes normally.
- With DM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> bus_err = 1 after 4 ACCESS cycles; a second run with ack on cycle 4 -> data returned and bus_err = 0.
